// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp codes and lamp decode helpers for the intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5,
    WALK = 3'd6
  } state_t;

  // Lamp order is {Red,Yellow,Green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Which green follows a pedestrian walk
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  function automatic logic [2:0] ns_lamp(state_t s);
    case (s)
      NS_G:    return GRN;
      NS_Y:    return YEL;
      default: return RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(state_t s);
    case (s)
      EW_G:    return GRN;
      EW_Y:    return YEL;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit phase down-counter: loads duration-1 on state entry, stops at zero,
// and can be frozen by hold.
module phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       hold,
  output logic [7:0] value,
  output logic       zero
);

  // Count down toward zero; never wraps below zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      value <= RST_VAL;
    else if (load)
      value <= load_val;
    else if (!hold && value != 8'd0)
      value <= value - 8'd1;
  end

  assign zero = (value == 8'd0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection controller with pedestrian walk service and
// emergency-vehicle preemption. Moore FSM, all outputs registered.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [7:0] G_LD = 8'(GREEN_CYC - 1);
  localparam logic [7:0] Y_LD = 8'(YELLOW_CYC - 1);
  localparam logic [7:0] A_LD = 8'(ALLRED_CYC - 1);
  localparam logic [7:0] W_LD = 8'(WALK_CYC - 1);

  state_t     state, state_nxt;
  logic       ped_pending;
  logic       next_dir;
  logic       tmr_load, tmr_hold, tmr_zero;
  logic [7:0] tmr_load_val, tmr_value;

  phase_timer #(.RST_VAL(A_LD)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .hold     (tmr_hold),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // Next-state decision and timer reload on every state change
  always_comb begin
    state_nxt    = state;
    tmr_hold     = 1'b0;
    case (state)
      NS_G: if (emerg || tmr_zero) state_nxt = NS_Y;
      NS_Y: if (tmr_zero) state_nxt = AR_A;
      EW_G: if (emerg || tmr_zero) state_nxt = EW_Y;
      EW_Y: if (tmr_zero) state_nxt = AR_B;
      AR_A, AR_B: begin
        // Emergency outranks a pending walk; clearance is held frozen at zero
        if (emerg)
          tmr_hold = (tmr_value == 8'd0);
        else if (tmr_zero)
          state_nxt = ped_pending ? WALK : ((state == AR_A) ? EW_G : NS_G);
      end
      WALK: begin
        if (emerg)
          state_nxt = (next_dir == DIR_EW) ? AR_A : AR_B;
        else if (tmr_zero)
          state_nxt = (next_dir == DIR_EW) ? EW_G : NS_G;
      end
      default: state_nxt = AR_B;
    endcase
    tmr_load = (state_nxt != state);
    case (state_nxt)
      NS_G, EW_G: tmr_load_val = G_LD;
      NS_Y, EW_Y: tmr_load_val = Y_LD;
      WALK:       tmr_load_val = W_LD;
      default:    tmr_load_val = A_LD;
    endcase
  end

  // State register with lamp outputs decoded from the next state so they are registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= AR_B;
      ns_light    <= RED;
      ew_light    <= RED;
      walk        <= 1'b0;
      phase       <= AR_B;
      ped_pending <= 1'b0;
      next_dir    <= DIR_NS;
    end else begin
      state    <= state_nxt;
      ns_light <= ns_lamp(state_nxt);
      ew_light <= ew_lamp(state_nxt);
      walk     <= (state_nxt == WALK);
      phase    <= state_nxt;
      if (state_nxt == WALK && state != WALK)
        ped_pending <= 1'b0;
      else if (ped_req)
        ped_pending <= 1'b1;
      if (state == AR_A && state_nxt == WALK)
        next_dir <= DIR_EW;
      else if (state == AR_B && state_nxt == WALK)
        next_dir <= DIR_NS;
    end
  end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: directed scenarios plus random
// ped/emerg stimulus, checked every cycle against a phase/remaining-cycles model.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  localparam int G = 4;
  localparam int Y = 2;
  localparam int A = 1;
  localparam int W = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ped_req = 1'b0;
  logic       emerg = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk;

  traffic_intersection_ctrl #(
    .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .WALK_CYC(W)
  ) dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .emerg(emerg),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cnt_walk = 0;
  int cnt_ewy = 0;

  // Model: current phase, cycles left in it (including this one), pending ped, green after walk
  state_t m_ph;
  state_t m_after;
  int     m_left;
  bit     m_pend;

  state_t seq[14] = '{AR_B, NS_G, NS_G, NS_G, NS_G, NS_Y, NS_Y,
                      AR_A, EW_G, EW_G, EW_G, EW_G, EW_Y, EW_Y};

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(state_t s);
    case (s)
      NS_G, EW_G: return G;
      NS_Y, EW_Y: return Y;
      WALK:       return W;
      default:    return A;
    endcase
  endfunction

  function automatic logic [2:0] exp_ns(state_t s);
    if (s == NS_G) return 3'b001;
    if (s == NS_Y) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_ew(state_t s);
    if (s == EW_G) return 3'b001;
    if (s == EW_Y) return 3'b010;
    return 3'b100;
  endfunction

  task automatic m_enter(state_t s);
    m_ph   = s;
    m_left = dur(s);
  endtask

  task automatic m_reset();
    m_ph    = AR_B;
    m_left  = A;
    m_pend  = 1'b0;
    m_after = NS_G;
  endtask

  task automatic m_step(bit p, bit e);
    bit     pend_old;
    bit     to_walk;
    state_t green;
    pend_old = m_pend;
    to_walk  = 1'b0;
    case (m_ph)
      NS_G: if (e || m_left == 1) m_enter(NS_Y); else m_left--;
      EW_G: if (e || m_left == 1) m_enter(EW_Y); else m_left--;
      NS_Y: if (m_left == 1) m_enter(AR_A); else m_left--;
      EW_Y: if (m_left == 1) m_enter(AR_B); else m_left--;
      AR_A, AR_B: begin
        green = (m_ph == AR_A) ? EW_G : NS_G;
        if (e) begin
          if (m_left > 1) m_left--;
        end else if (m_left == 1) begin
          if (pend_old) begin
            m_after = green;
            to_walk = 1'b1;
            m_enter(WALK);
          end else begin
            m_enter(green);
          end
        end else begin
          m_left--;
        end
      end
      WALK: begin
        if (e) m_enter((m_after == EW_G) ? AR_A : AR_B);
        else if (m_left == 1) m_enter(m_after);
        else m_left--;
      end
      default: m_reset();
    endcase
    if (to_walk) m_pend = 1'b0;
    else if (p) m_pend = 1'b1;
  endtask

  task automatic check_all();
    chk("ns_light", {5'd0, ns_light}, {5'd0, exp_ns(m_ph)});
    chk("ew_light", {5'd0, ew_light}, {5'd0, exp_ew(m_ph)});
    chk("walk", {7'd0, walk}, {7'd0, (m_ph == WALK)});
    chk("phase", {5'd0, phase}, {5'd0, m_ph});
  endtask

  // One clock: drive inputs, advance model at the edge, check at the falling edge
  task automatic cyc(bit p, bit e);
    ped_req = p;
    emerg   = e;
    @(posedge clk);
    m_step(p, e);
    @(negedge clk);
    check_all();
    if (walk) cnt_walk++;
    if (ew_light == 3'b010) cnt_ewy++;
  endtask

  task automatic wait_phase(state_t s, bit e, int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_ph == s) break;
      cyc(1'b0, e);
    end
    chk("wait_phase", {5'd0, phase}, {5'd0, s});
  endtask

  initial begin
    bit em_r;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ns", {5'd0, ns_light}, 8'h04);
    chk("rst_ew", {5'd0, ew_light}, 8'h04);
    chk("rst_walk", {7'd0, walk}, 8'h00);
    reset = 1'b0;
    check_all();

    // Fixed cycle sequence from reset, two full rounds
    chk("seq", {5'd0, phase}, {5'd0, seq[0]});
    for (int i = 1; i < 29; i++) begin
      cyc(1'b0, 1'b0);
      chk("seq", {5'd0, phase}, {5'd0, seq[i % 14]});
    end

    // Single ped pulse in NS_G: walk served between AR_A and EW_G
    wait_phase(NS_G, 1'b0, 20);
    cyc(1'b1, 1'b0);
    cnt_walk = 0;
    wait_phase(EW_G, 1'b0, 40);
    chk("ped_walk_cnt", 8'(cnt_walk), 8'd3);
    chk("ped_pend_clr", {7'd0, dut.ped_pending}, 8'd0);

    // Emergency rising in cycle 2 of EW_G
    cnt_ewy = 0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("em_ewy", {5'd0, phase}, {5'd0, EW_Y});
    repeat (5) cyc(1'b0, 1'b1);
    chk("em_hold_arb", {5'd0, phase}, {5'd0, AR_B});
    cyc(1'b0, 1'b0);
    chk("em_release_nsg", {5'd0, phase}, {5'd0, NS_G});
    chk("em_ewy_cnt", 8'(cnt_ewy), 8'd2);

    // Emergency during walk cycle 2
    cyc(1'b1, 1'b0);
    cnt_walk = 0;
    wait_phase(WALK, 1'b0, 30);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("walk_abort", {7'd0, walk}, 8'd0);
    repeat (3) cyc(1'b0, 1'b1);
    chk("walk_abort_ara", {5'd0, phase}, {5'd0, AR_A});
    cyc(1'b0, 1'b0);
    chk("walk_abort_ewg", {5'd0, phase}, {5'd0, EW_G});
    repeat (20) cyc(1'b0, 1'b0);
    chk("walk_abort_cnt", 8'(cnt_walk), 8'd2);

    // Ped and emergency both pending at AR_A expiry
    wait_phase(NS_G, 1'b0, 40);
    cyc(1'b1, 1'b0);
    wait_phase(AR_A, 1'b1, 20);
    repeat (3) cyc(1'b0, 1'b1);
    chk("both_hold", {5'd0, phase}, {5'd0, AR_A});
    cnt_walk = 0;
    cyc(1'b0, 1'b0);
    chk("both_walk", {5'd0, phase}, {5'd0, WALK});
    wait_phase(EW_G, 1'b0, 10);
    chk("both_walk_cnt", 8'(cnt_walk), 8'd3);

    // Random ped pulses and emergency episodes
    em_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0) em_r = ~em_r;
      cyc(($urandom_range(0, 9) == 0), em_r);
    end
    repeat (5) cyc(1'b0, 1'b0);

    // Async reset in the middle of EW_Y
    wait_phase(EW_Y, 1'b0, 60);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_ns", {5'd0, ns_light}, 8'h04);
    chk("arst_ew", {5'd0, ew_light}, 8'h04);
    chk("arst_walk", {7'd0, walk}, 8'h00);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all();
    for (int i = 1; i < 15; i++) begin
      cyc(1'b0, 1'b0);
      chk("arst_seq", {5'd0, phase}, {5'd0, seq[i % 14]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
